layer_ack_sequencer: RTL and testbench

Parametrised acknowledge sequencer for one neural-network layer. It counts `ack` handshakes from the layer's MAC datapath over `N_IN` inputs and `N_OUT` neurons. It exposes the current input/neuron indices for operand addressing and signals neuron-complete (`ack_mac`) and layer-complete (`ack_layer`). It replaces the fixed three-count, sticky-only counter with configurable depth, a second counting dimension, explicit start/busy control and a selectable completion mode.

---
 rtl/layer_ack_sequencer.sv | 131 +++++++++++++
 tb/tb_layer_ack_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/layer_ack_sequencer.sv
// Acknowledge sequencer for one NN layer: counts MAC acks over N_IN inputs x N_OUT neurons
// and flags neuron-complete (ack_mac) and layer-complete (ack_layer). Registers update on the falling edge.
module layer_ack_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int STICKY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  output logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_idx,
  output logic             busy,
  output logic             ack_mac,
  output logic             ack_layer
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(N_OUT - 1);
  localparam logic [IN_W-1:0]  ONE_IN   = IN_W'(1);
  localparam logic [OUT_W-1:0] ONE_OUT  = OUT_W'(1);

  state_t             state_r, state_s;
  logic [IN_W-1:0]    in_idx_r, in_idx_s;
  logic [OUT_W-1:0]   out_idx_r, out_idx_s;
  logic               busy_r, busy_s;
  logic               ack_mac_r, ack_mac_s;
  logic               ack_layer_r, ack_layer_s;

  // State and output registers, falling edge, synchronous active-low reset
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      in_idx_r    <= {IN_W{1'b0}};
      out_idx_r   <= {OUT_W{1'b0}};
      busy_r      <= 1'b0;
      ack_mac_r   <= 1'b0;
      ack_layer_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_idx_r    <= in_idx_s;
      out_idx_r   <= out_idx_s;
      busy_r      <= busy_s;
      ack_mac_r   <= ack_mac_s;
      ack_layer_r <= ack_layer_s;
    end
  end

  // Next-state and next-output logic; ack_mac is a pulse so it defaults low
  always_comb begin
    state_s     = state_r;
    in_idx_s    = in_idx_r;
    out_idx_s   = out_idx_r;
    busy_s      = busy_r;
    ack_mac_s   = 1'b0;
    ack_layer_s = ack_layer_r;
    case (state_r)
      IDLE: begin
        ack_layer_s = 1'b0;
        if (start) begin
          state_s   = RUN;
          in_idx_s  = {IN_W{1'b0}};
          out_idx_s = {OUT_W{1'b0}};
          busy_s    = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      RUN: begin
        if (ack) begin
          if (in_idx_r == LAST_IN) begin
            in_idx_s  = {IN_W{1'b0}};
            ack_mac_s = 1'b1;
            if (out_idx_r == LAST_OUT) begin
              out_idx_s   = {OUT_W{1'b0}};
              state_s     = DONE;
              busy_s      = 1'b0;
              ack_layer_s = 1'b1;
            end else begin
              out_idx_s = out_idx_r + ONE_OUT;
            end
          end else begin
            in_idx_s = in_idx_r + ONE_IN;
          end
        end else begin
          in_idx_s = in_idx_r;
        end
      end
      DONE: begin
        // Sticky mode waits for a restart; pulse mode falls straight back to IDLE
        if (STICKY != 0) begin
          if (start) begin
            state_s     = RUN;
            in_idx_s    = {IN_W{1'b0}};
            out_idx_s   = {OUT_W{1'b0}};
            busy_s      = 1'b1;
            ack_layer_s = 1'b0;
          end else begin
            ack_layer_s = 1'b1;
          end
        end else begin
          state_s     = IDLE;
          ack_layer_s = 1'b0;
        end
      end
      default: begin
        state_s     = IDLE;
        in_idx_s    = {IN_W{1'b0}};
        out_idx_s   = {OUT_W{1'b0}};
        busy_s      = 1'b0;
        ack_layer_s = 1'b0;
      end
    endcase
  end

  assign in_idx    = in_idx_r;
  assign out_idx   = out_idx_r;
  assign busy      = busy_r;
  assign ack_mac   = ack_mac_r;
  assign ack_layer = ack_layer_r;

endmodule

// File: tb/tb_layer_ack_sequencer.sv
// Bench for layer_ack_sequencer: a default sticky 3x2 instance (A) and a pulse-mode 1x1 instance (B)
// share the clock; expected outputs of both are queued per step and compared after each falling edge.
module tb_layer_ack_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;
  logic [1:0] in_idx_a;
  logic [0:0] out_idx_a, in_idx_b, out_idx_b;
  logic busy_a, ack_mac_a, ack_layer_a, busy_b, ack_mac_b, ack_layer_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] sb[$];
  logic [10:0] exp_v;
  logic [10:0] obs;

  int in_tab[6]  = '{1, 2, 0, 1, 2, 0};
  int out_tab[6] = '{0, 0, 1, 1, 1, 0};

  always #5 clk = ~clk;

  layer_ack_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ack(ack_a),
    .in_idx(in_idx_a), .out_idx(out_idx_a), .busy(busy_a),
    .ack_mac(ack_mac_a), .ack_layer(ack_layer_a)
  );

  layer_ack_sequencer #(.N_IN(1), .N_OUT(1), .IN_W(1), .OUT_W(1), .STICKY(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ack(ack_b),
    .in_idx(in_idx_b), .out_idx(out_idx_b), .busy(busy_b),
    .ack_mac(ack_mac_b), .ack_layer(ack_layer_b)
  );

  assign obs = {busy_a, ack_mac_a, ack_layer_a, out_idx_a, in_idx_a,
                busy_b, ack_mac_b, ack_layer_b, out_idx_b, in_idx_b};

  function automatic logic [5:0] pa(input logic b, input logic m, input logic l, input int o, input int i);
    logic [5:0] r;
    r = {b, m, l, o[0], i[1:0]};
    return r;
  endfunction

  function automatic logic [4:0] pb(input logic b, input logic m, input logic l, input int o, input int i);
    logic [4:0] r;
    r = {b, m, l, o[0], i[0]};
    return r;
  endfunction

  localparam logic [5:0] DONE_A = 6'b001000;
  localparam logic [5:0] RUN0_A = 6'b100000;

  // Drive both instances for one clock, queue the expectation, return half a period after the edge
  task automatic step(input logic sa, input logic aa, input logic [5:0] ea,
                      input logic sbv, input logic ab, input logic [4:0] eb);
    start_a = sa; ack_a = aa; start_b = sbv; ack_b = ab;
    sb.push_back({ea, eb});
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_hold[%0d] got=%b exp=%b", i, obs, exp_v); end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_ack_only[%0d] got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  // start (optionally with a coincident ack that must not count), then six back-to-back acks
  task automatic full_pass_a(input logic ack_on_start);
    step(1'b1, ack_on_start, RUN0_A, 1'b0, 1'b0, 5'd0);
    exp_v = sb.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pass_start got=%b exp=%b", obs, exp_v); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, pa(k != 5, (k == 2) || (k == 5), k == 5, out_tab[k], in_tab[k]), 1'b0, 1'b0, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pass_ack[%0d] got=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_back_to_back;
    full_pass_a(1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, DONE_A, 1'b0, 1'b0, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_extra[%0d] got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  task automatic test_sticky;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i % 2) == 1, DONE_A, 1'b0, 1'b0, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL sticky_hold[%0d] got=%b exp=%b", i, obs, exp_v); end
    end
    step(1'b1, 1'b1, RUN0_A, 1'b0, 1'b0, 5'd0);
    exp_v = sb.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sticky_restart got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_gapped;
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < 3; g++) begin
        step(1'b0, g == 0, pa(k != 5, ((k == 2) || (k == 5)) && (g == 0), k == 5, out_tab[k], in_tab[k]),
             1'b0, 1'b0, 5'd0);
        exp_v = sb.pop_front(); n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL gapped[%0d.%0d] got=%b exp=%b", k, g, obs, exp_v); end
      end
    end
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b0, RUN0_A, 1'b0, 1'b0, 5'd0);
    exp_v = sb.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_start got=%b exp=%b", obs, exp_v); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, pa(1'b1, k == 2, 1'b0, out_tab[k], in_tab[k]), 1'b0, 1'b0, 5'd0);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_ack[%0d] got=%b exp=%b", k, obs, exp_v); end
    end
    rst = 1'b0;
    step(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 5'd0);
    rst = 1'b1;
    exp_v = sb.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_cleared got=%b exp=%b", obs, exp_v); end
    full_pass_a(1'b0);
  endtask

  task automatic test_pulse_mode;
    logic [4:0] eb_tab[8];
    logic       sb_tab[8];
    logic       ab_tab[8];
    eb_tab = '{pb(1'b1, 1'b0, 1'b0, 0, 0), pb(1'b0, 1'b1, 1'b1, 0, 0), 5'd0, 5'd0,
               pb(1'b1, 1'b0, 1'b0, 0, 0), pb(1'b0, 1'b1, 1'b1, 0, 0), 5'd0, 5'd0};
    sb_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ab_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, DONE_A, sb_tab[i], ab_tab[i], eb_tab[i]);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pulse[%0d] got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_sticky;
    test_gapped;
    test_mid_reset;
    test_pulse_mode;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
